// File: rtl/seven_seg_scanner_if.sv
// Bus bundle for the four-digit seven-segment scanner: BCD load/control in,
// multiplexed segment/anode drive and status out.
interface seven_seg_scanner_if;
    logic [15:0] Digits;
    logic        Load;
    logic        Lz_en;
    logic        Blanking;
    logic [6:0]  Display;
    logic [3:0]  Anode;
    logic        Frame_done;
    logic        Loaded;
    logic        Pending;

    modport master (
        output Digits, Load, Lz_en, Blanking,
        input  Display, Anode, Frame_done, Loaded, Pending
    );

    modport slave (
        input  Digits, Load, Lz_en, Blanking,
        output Display, Anode, Frame_done, Loaded, Pending
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with double-buffered BCD data
// that only changes at frame boundaries, leading-zero suppression and blanking.
module seven_seg_scanner #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                clock,
    input  logic                reset,
    seven_seg_scanner_if.slave  bus
);

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);
    localparam logic [6:0]  SEG_BLANK  = 7'b111_1111;

    logic [15:0] count_r;
    logic [1:0]  index_r;
    logic [15:0] hold_r;
    logic [15:0] shadow_r;
    logic        pending_r;
    logic        frame_done_r;
    logic        loaded_r;
    logic [3:0]  anode_r;
    logic [6:0]  display_r;

    logic        tick_s;
    logic        wrap_s;
    logic [3:0]  nibble_s;
    logic        upper_zero_s;
    logic [6:0]  seg_s;

    function automatic logic [6:0] seg_code(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'b000_0001;
            4'd1:    code = 7'b100_1111;
            4'd2:    code = 7'b001_0010;
            4'd3:    code = 7'b000_0110;
            4'd4:    code = 7'b100_1100;
            4'd5:    code = 7'b010_0100;
            4'd6:    code = 7'b010_0000;
            4'd7:    code = 7'b000_1111;
            4'd8:    code = 7'b000_0000;
            4'd9:    code = 7'b000_0100;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    assign tick_s = (count_r == LAST_COUNT);
    assign wrap_s = tick_s && (index_r == 2'd3);

    // Prescaler and digit index: each digit slot lasts PRESCALE clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 16'd0;
            index_r <= 2'd0;
        end else if (tick_s) begin
            count_r <= 16'd0;
            index_r <= index_r + 2'd1;
        end else begin
            count_r <= count_r + 16'd1;
            index_r <= index_r;
        end
    end

    // Hold/shadow double buffer; a Load on the wrap tick defers the transfer a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_r       <= 16'd0;
            shadow_r     <= 16'd0;
            pending_r    <= 1'b0;
            loaded_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            if (bus.Load) begin
                hold_r    <= bus.Digits;
                pending_r <= 1'b1;
                loaded_r  <= 1'b0;
            end else if (wrap_s && pending_r) begin
                shadow_r  <= hold_r;
                pending_r <= 1'b0;
                loaded_r  <= 1'b1;
            end else begin
                loaded_r  <= 1'b0;
            end
        end
    end

    // Select the active nibble and whether it and everything above it is zero.
    always_comb begin
        nibble_s     = 4'd0;
        upper_zero_s = 1'b0;
        case (index_r)
            2'd0: begin
                nibble_s     = shadow_r[3:0];
                upper_zero_s = 1'b0;
            end
            2'd1: begin
                nibble_s     = shadow_r[7:4];
                upper_zero_s = (shadow_r[15:4] == 12'd0);
            end
            2'd2: begin
                nibble_s     = shadow_r[11:8];
                upper_zero_s = (shadow_r[15:8] == 8'd0);
            end
            2'd3: begin
                nibble_s     = shadow_r[15:12];
                upper_zero_s = (shadow_r[15:12] == 4'd0);
            end
            default: begin
                nibble_s     = 4'd0;
                upper_zero_s = 1'b0;
            end
        endcase
    end

    // Segment priority: blanking, then leading-zero suppression, then decode.
    always_comb begin
        seg_s = SEG_BLANK;
        if (bus.Blanking) begin
            seg_s = SEG_BLANK;
        end else if (bus.Lz_en && upper_zero_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_code(nibble_s);
        end
    end

    // Anode and segments registered together so they never disagree.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_r   <= 4'b1110;
            display_r <= 7'b000_0001;
        end else begin
            anode_r   <= ~(4'b0001 << index_r);
            display_r <= seg_s;
        end
    end

    assign bus.Anode      = anode_r;
    assign bus.Display    = display_r;
    assign bus.Frame_done = frame_done_r;
    assign bus.Loaded     = loaded_r;
    assign bus.Pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (PRESCALE=4): table vectors,
// hand-written corner sequences and random stimulus against a frame-level model.
module tb_seven_seg_scanner;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seven_seg_scanner_if ifc();

    seven_seg_scanner #(.PRESCALE(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        logic [15:0]      digits;
        logic             lz;
        logic [3:0][6:0]  seg;
    } vec_t;

    vec_t tbl [6];

    int n_vec = 0;
    int n_err = 0;
    int loaded_seen = 0;

    // Model state: edges since reset release plus the two data buffers.
    int          t;
    logic [15:0] m_hold, m_shadow;
    logic        m_pending;
    logic [6:0]  e_display;
    logic [3:0]  e_anode;
    logic        e_fd, e_loaded;
    logic        cur_lz = 1'b0;
    logic        cur_bl = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b000_0001;
            4'd1: return 7'b100_1111;
            4'd2: return 7'b001_0010;
            4'd3: return 7'b000_0110;
            4'd4: return 7'b100_1100;
            4'd5: return 7'b010_0100;
            4'd6: return 7'b010_0000;
            4'd7: return 7'b000_1111;
            4'd8: return 7'b000_0000;
            4'd9: return 7'b000_0100;
            default: return 7'b111_1111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int k,
                                           input logic lz, input logic bl);
        if (bl) return 7'h7F;
        if (lz && k > 0 && (sh >> (4 * k)) == 16'd0) return 7'h7F;
        return seg_of(sh[4*k +: 4]);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_hold = 16'd0;
        m_shadow = 16'd0;
        m_pending = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] dg);
        int  k;
        bit  wrap;
        ifc.Load     = ld;
        ifc.Digits   = dg;
        ifc.Lz_en    = cur_lz;
        ifc.Blanking = cur_bl;
        @(posedge clock);
        k    = (t / P) % 4;
        wrap = (t % FRAME) == FRAME - 1;
        e_anode   = ~(4'b0001 << k);
        e_display = exp_seg(m_shadow, k, cur_lz, cur_bl);
        e_fd      = wrap;
        e_loaded  = wrap && m_pending && !ld;
        if (ld) begin
            m_hold = dg;
            m_pending = 1'b1;
        end else if (wrap && m_pending) begin
            m_shadow = m_hold;
            m_pending = 1'b0;
        end
        t++;
        #1;
        chk("anode",      {12'd0, ifc.Anode},      {12'd0, e_anode});
        chk("display",    {9'd0, ifc.Display},     {9'd0, e_display});
        chk("frame_done", {15'd0, ifc.Frame_done}, {15'd0, e_fd});
        chk("loaded",     {15'd0, ifc.Loaded},     {15'd0, e_loaded});
        chk("pending",    {15'd0, ifc.Pending},    {15'd0, m_pending});
        if (ifc.Loaded) loaded_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0);
    endtask

    task automatic wait_loaded(input string name);
        int w;
        w = 0;
        loaded_seen = 0;
        while (loaded_seen == 0 && w < 3 * FRAME) begin
            step(1'b0, 16'd0);
            w++;
        end
        chk(name, {15'd0, loaded_seen != 0}, 16'd1);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        tbl[1] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h24, 7'h01}};
        tbl[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        tbl[3] = '{16'hA9F0, 1'b0, {7'h7F, 7'h04, 7'h7F, 7'h01}};
        tbl[4] = '{16'h0078, 1'b0, {7'h01, 7'h01, 7'h0F, 7'h00}};
        tbl[5] = '{16'h6000, 1'b1, {7'h20, 7'h01, 7'h01, 7'h01}};

        ifc.Digits = 16'd0;
        ifc.Load = 1'b0;
        ifc.Lz_en = 1'b0;
        ifc.Blanking = 1'b0;
        #1 reset = 1'b0;
        #10;
        chk("rst_anode",   {12'd0, ifc.Anode},      16'h000E);
        chk("rst_display", {9'd0, ifc.Display},     16'h0001);
        chk("rst_pending", {15'd0, ifc.Pending},    16'd0);
        chk("rst_fd",      {15'd0, ifc.Frame_done}, 16'd0);
        chk("rst_loaded",  {15'd0, ifc.Loaded},     16'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Table vectors: load, wait for the transfer, then check one full frame.
        for (int i = 0; i < 6; i++) begin
            int d;
            cur_lz = tbl[i].lz;
            step(1'b1, tbl[i].digits);
            wait_loaded("tbl_loaded");
            for (int j = 0; j < FRAME; j++) begin
                step(1'b0, 16'd0);
                d = 0;
                for (int k = 0; k < 4; k++) if (ifc.Anode[k] == 1'b0) d = k;
                chk("tbl_digit", {9'd0, ifc.Display}, {9'd0, tbl[i].seg[d]});
            end
        end

        // Newest load waits for the frame boundary; load on wrap tick defers a frame.
        cur_lz = 1'b0;
        step(1'b1, 16'h2222);
        wait_loaded("hs_2222");
        while (((t / P) % 4) != 1) step(1'b0, 16'd0);
        step(1'b1, 16'h1111);
        chk("hs_pending", {15'd0, ifc.Pending}, 16'd1);
        wait_loaded("hs_1111");
        step(1'b0, 16'd0);
        chk("hs_d0", {9'd0, ifc.Display}, 16'h004F);
        while ((t % FRAME) != FRAME - 1) step(1'b0, 16'd0);
        step(1'b1, 16'h5555);
        loaded_seen = 0;
        idle(FRAME - 1);
        chk("wrap_no_early", loaded_seen[15:0], 16'd0);
        step(1'b0, 16'd0);
        chk("wrap_late", {15'd0, ifc.Loaded}, 16'd1);

        // One frame of blanking.
        cur_bl = 1'b1;
        idle(FRAME);
        cur_bl = 1'b0;
        idle(2);

        // Asynchronous reset mid-scan with data pending.
        step(1'b1, 16'h8888);
        while (((t / P) % 4) != 2) step(1'b0, 16'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_anode",   {12'd0, ifc.Anode},   16'h000E);
        chk("mid_display", {9'd0, ifc.Display},  16'h0001);
        chk("mid_pending", {15'd0, ifc.Pending}, 16'd0);
        chk("mid_loaded",  {15'd0, ifc.Loaded},  16'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        loaded_seen = 0;
        idle(2 * FRAME);
        chk("mid_no_loaded", loaded_seen[15:0], 16'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cur_lz = ~cur_lz;
            if ($urandom_range(0, 19) == 0) cur_bl = ~cur_bl;
            step($urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
